spi_host_ctrl: RTL and testbench

- SPI initiator that drives the digitizer's SPI command/data port from the local control logic.
- A one-cycle start launches a frame: a 4-bit command in an 8-bit command frame, then a DATA_W-bit data phase (write: shift out; read: shift in).
- SPI mode 0 (CPOL=0, CPHA=0), MSB first; single chip select.
- Sits between the control/register logic and the SPI pins.

---
 rtl/spi_host_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_spi_host_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_host_ctrl
// Purpose  : SPI mode-0 initiator for the digitizer command/data port. A
//            one-cycle start sends an 8-bit command frame ({4'b0, cmd}), waits
//            GAP_CYC cycles with SCLK low, then runs a DATA_W-bit data phase
//            (write: shift wr_data out; read: shift MISO in), MSB first.
// Ports    : clk, rst_n       - clock, synchronous active-low reset
//            start, cmd,      - request strobe (taken only when idle), opcode
//            wr_data            and write payload captured on accept
//            busy, done, err  - frame in progress, end-of-frame pulse, bad-
//                               opcode pulse (coincident with done)
//            rd_data          - last read result, updated at done of a read
//            spi_sclk/cs_n/mosi/miso - SPI pins
// Revision : 1.0  initial release
// ============================================================================
module spi_host_ctrl #(
   parameter int         CLK_DIV = 4,
   parameter int         DATA_W  = 16,
   parameter int         GAP_CYC = 4,
   parameter int         CS_HIGH = 4,
   parameter logic [3:0] RD_CMD  = 4'h1,
   parameter logic [3:0] WR_CMD  = 4'h2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [3:0]        cmd,
   input  logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] rd_data,
   output logic              spi_sclk,
   output logic              spi_cs_n,
   output logic              spi_mosi,
   input  logic              spi_miso
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CMD     = 3'd1,
      S_GAP     = 3'd2,
      S_DATA    = 3'd3,
      S_FINISH  = 3'd4,
      S_RECOVER = 3'd5
   } state_e;

   localparam logic [7:0] c_div_last  = 8'(CLK_DIV - 1);
   localparam logic [7:0] c_gap_last  = 8'(GAP_CYC - 1);
   localparam logic [7:0] c_csh_last  = 8'(CS_HIGH - 1);
   localparam logic [5:0] c_cmd_last  = 6'd7;
   localparam logic [5:0] c_data_last = 6'(DATA_W - 1);

   state_e              state_q, state_d;
   logic [7:0]          div_q, div_d;      // cycles within an SCLK half-period
   logic [5:0]          bit_q, bit_d;      // bit index within CMD or DATA
   logic [7:0]          cnt_q, cnt_d;      // GAP / FINISH / RECOVER length
   logic                sclk_q, sclk_d;
   logic                cs_n_q, cs_n_d;
   logic                mosi_q, mosi_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                err_flag_q, err_flag_d;
   logic [3:0]          cmd_q, cmd_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   tx_q, tx_d;
   logic [DATA_W-1:0]   rx_q, rx_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;

   logic                w_half_end;
   logic                w_is_rd;
   logic                w_valid;
   logic [5:0]          w_bit_last;

   assign w_half_end = (div_q == c_div_last);
   assign w_is_rd    = (cmd_q == RD_CMD);
   assign w_valid    = w_is_rd || (cmd_q == WR_CMD);
   assign w_bit_last = (state_q == S_CMD) ? c_cmd_last : c_data_last;

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      bit_d      = bit_q;
      cnt_d      = cnt_q;
      sclk_d     = sclk_q;
      cs_n_d     = cs_n_q;
      mosi_d     = mosi_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      err_flag_d = err_flag_q;
      cmd_d      = cmd_q;
      wdata_d    = wdata_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      rd_data_d  = rd_data_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_CMD;
               cmd_d      = cmd;
               wdata_d    = wr_data;
               cs_n_d     = 1'b0;
               sclk_d     = 1'b0;
               div_d      = 8'd0;
               bit_d      = 6'd0;
               err_flag_d = 1'b0;
               // Command byte is left-aligned in the shifter; its MSB is
               // always 0 because the upper nibble of the frame is zero.
               tx_d       = DATA_W'({4'b0000, cmd}) << (DATA_W - 8);
               mosi_d     = 1'b0;
            end
         end

         S_CMD, S_DATA: begin
            if (w_half_end) begin
               div_d = 8'd0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
                  if (state_q == S_DATA) begin
                     rx_d = {rx_q[DATA_W-2:0], spi_miso};
                  end
               end else begin
                  sclk_d = 1'b0;
                  if (bit_q == w_bit_last) begin
                     bit_d  = 6'd0;
                     mosi_d = 1'b0;
                     cnt_d  = 8'd0;
                     if (state_q == S_CMD && w_valid) begin
                        state_d = S_GAP;
                     end else begin
                        // Bad opcode skips the data phase entirely.
                        if (state_q == S_CMD) begin
                           err_flag_d = 1'b1;
                        end
                        state_d = S_FINISH;
                     end
                  end else begin
                     bit_d  = bit_q + 6'd1;
                     tx_d   = tx_q << 1;
                     mosi_d = tx_q[DATA_W-2];
                  end
               end
            end else begin
               div_d = div_q + 8'd1;
            end
         end

         S_GAP: begin
            if (cnt_q == c_gap_last) begin
               state_d = S_DATA;
               div_d   = 8'd0;
               bit_d   = 6'd0;
               rx_d    = '0;
               tx_d    = w_is_rd ? '0 : wdata_q;
               mosi_d  = w_is_rd ? 1'b0 : wdata_q[DATA_W-1];
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         S_FINISH: begin
            if (cnt_q == c_div_last) begin
               state_d = S_RECOVER;
               cs_n_d  = 1'b1;
               done_d  = 1'b1;
               err_d   = err_flag_q;
               cnt_d   = 8'd0;
               if (w_is_rd) begin
                  rd_data_d = rx_q;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         S_RECOVER: begin
            // The done cycle is the first of the CS_HIGH recovery cycles.
            if (cnt_q == c_csh_last) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         div_q      <= 8'd0;
         bit_q      <= 6'd0;
         cnt_q      <= 8'd0;
         sclk_q     <= 1'b0;
         cs_n_q     <= 1'b1;
         mosi_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_flag_q <= 1'b0;
         cmd_q      <= 4'd0;
         wdata_q    <= '0;
         tx_q       <= '0;
         rx_q       <= '0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         bit_q      <= bit_d;
         cnt_q      <= cnt_d;
         sclk_q     <= sclk_d;
         cs_n_q     <= cs_n_d;
         mosi_q     <= mosi_d;
         done_q     <= done_d;
         err_q      <= err_d;
         err_flag_q <= err_flag_d;
         cmd_q      <= cmd_d;
         wdata_q    <= wdata_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign done     = done_q;
   assign err      = err_q;
   assign rd_data  = rd_data_q;
   assign spi_sclk = sclk_q;
   assign spi_cs_n = cs_n_q;
   assign spi_mosi = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_host_ctrl
// Purpose  : Self-checking bench for spi_host_ctrl. A pin-level monitor
//            records the MOSI bit seen at each SCLK rise, SCLK high/low run
//            lengths and chip-select gaps, and a mode-0 responder drives MISO.
//            Expected streams, latencies and read data come from the frame
//            rules (opcode byte + payload, cycle arithmetic).
// Revision : 1.0  initial release
// ============================================================================
module tb_spi_host_ctrl;

   localparam int N   = 4;
   localparam int DW  = 16;
   localparam int G   = 4;
   localparam int CSH = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [3:0]    cmd = 4'd0;
   logic [DW-1:0] wr_data = '0;
   logic          miso = 1'b0;
   wire           busy, done, err, sclk, cs_n, mosi;
   wire  [DW-1:0] rd_data;

   spi_host_ctrl #(
      .CLK_DIV (N),
      .DATA_W  (DW),
      .GAP_CYC (G),
      .CS_HIGH (CSH),
      .RD_CMD  (4'h1),
      .WR_CMD  (4'h2)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .cmd      (cmd),
      .wr_data  (wr_data),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .rd_data  (rd_data),
      .spi_sclk (sclk),
      .spi_cs_n (cs_n),
      .spi_mosi (mosi),
      .spi_miso (miso)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chkn(input string tag, input int obs, input int exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic chkv(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- pin monitor + mode-0 responder ----------------
   int          rise_cnt = 0;
   int          lo_run = 0;
   int          hi_run = 0;
   int          viol = 0;
   int          fall_cnt = 0;
   int          cs_hi_run = 0;
   int          last_cs_gap = 0;
   int          done_cnt = 0;
   int          lo_at [0:63];
   logic        sclk_prev = 1'b0;
   logic        cs_prev = 1'b1;
   logic [39:0] mosi_bits = '0;
   logic [23:0] resp = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         sclk_prev = 1'b0;
         cs_prev   = 1'b1;
         hi_run    = 0;
         lo_run    = 0;
      end else begin
         if (done) done_cnt++;
         if (cs_n) begin
            cs_hi_run++;
            lo_run = 0;
            if (sclk) viol++;
         end else begin
            if (cs_prev) begin
               last_cs_gap = cs_hi_run;
               fall_cnt    = 0;
               miso        = resp[23];
            end
            cs_hi_run = 0;
         end
         if (sclk) begin
            if (!sclk_prev) begin
               mosi_bits = {mosi_bits[38:0], mosi};
               if (rise_cnt < 64) lo_at[rise_cnt] = lo_run;
               rise_cnt++;
               lo_run = 0;
               hi_run = 0;
            end
            hi_run++;
         end else begin
            if (sclk_prev) begin
               if (hi_run != N) viol++;
               fall_cnt++;
               if (fall_cnt < 24) miso = resp[23 - fall_cnt];
            end
            if (!cs_n) lo_run++;
         end
         sclk_prev = sclk;
         cs_prev   = cs_n;
      end
   end

   // ---------------- reference expectations ----------------
   logic [DW-1:0] exp_rd = '0;

   // Caller must be at posedge+1 of a cycle in which the DUT is idle; the
   // task returns at posedge+1 of the first cycle busy is low again.
   task automatic run_frame(input logic [3:0] c, input logic [DW-1:0] wd, input logic [DW-1:0] rv);
      logic        valid;
      logic        is_rd;
      int          exp_lat;
      logic [39:0] exp_bits;
      int          t0;
      int          dc;
      logic        found;
      valid    = (c == 4'h1) || (c == 4'h2);
      is_rd    = (c == 4'h1);
      exp_lat  = valid ? (1 + 16*N + G + 2*N*DW + N) : (1 + 17*N);
      exp_bits = valid ? {16'h0, 4'h0, c, (is_rd ? 16'h0 : wd)} : {32'h0, 4'h0, c};
      if (is_rd) exp_rd = rv;
      resp      = {8'($urandom), rv};
      rise_cnt  = 0;
      mosi_bits = '0;
      viol      = 0;

      start = 1'b1; cmd = c; wr_data = wd; t0 = cyc;
      @(posedge clk); #1;
      start = 1'b0; cmd = 4'($urandom); wr_data = 16'($urandom);
      chk1("busy_c1", busy, 1'b1);
      chk1("csn_c1", cs_n, 1'b0);
      chk1("mosi_c1", mosi, 1'b0);

      found = 1'b0;
      dc    = 0;
      for (int k = 0; k < 400 && !found; k++) begin
         @(posedge clk); #1;
         start = (k == 40);
         if (done) begin
            found = 1'b1;
            dc    = cyc;
         end
      end
      chk1("done_seen", found, 1'b1);
      if (found) begin
         chkn("done_latency", dc - t0, exp_lat);
         chk1("err_at_done", err, !valid);
         chk1("csn_at_done", cs_n, 1'b1);
         chkn("rd_data_at_done", int'(rd_data), int'(exp_rd));
         start = 1'b1;   // pulse in the done cycle: must be ignored
         @(posedge clk); #1;
         start = 1'b0;
         chk1("done_one_cycle", done, 1'b0);
         chk1("err_one_cycle", err, 1'b0);
         for (int k = 0; k < 20 && busy; k++) begin
            @(posedge clk); #1;
         end
         chkn("busy_release", cyc - dc, CSH);
         chkn("rd_data_hold", int'(rd_data), int'(exp_rd));
      end
      chkn("sclk_rises", rise_cnt, valid ? 8 + DW : 8);
      chkv("mosi_stream", mosi_bits, exp_bits);
      chkn("first_low_half", lo_at[0], N);
      if (valid) chkn("gap_low_run", lo_at[8], G + N);
      chkn("sclk_shape_viol", viol, 0);
      chk1("cs_gap_min", last_cs_gap >= CSH, 1'b1);
   endtask

   // ---------------- directed + randomized sequence ----------------
   initial begin
      int          r;
      int          dc0;
      logic [3:0]  c;

      // Reset held for 3 cycles while start toggles.
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         start = ~start; cmd = 4'h2;
         chk1("rst_csn", cs_n, 1'b1);
         chk1("rst_sclk", sclk, 1'b0);
         chk1("rst_busy", busy, 1'b0);
         chkn("rst_rd_data", int'(rd_data), 0);
      end
      rst_n = 1'b1; start = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk1("idle_csn", cs_n, 1'b1);
      chk1("idle_busy", busy, 1'b0);
      chkn("idle_rises", rise_cnt, 0);

      // Directed: write, back-to-back read, invalid opcode.
      run_frame(4'h2, 16'hA5C3, 16'($urandom));
      run_frame(4'h1, 16'($urandom), 16'h3C5A);
      run_frame(4'h7, 16'($urandom), 16'($urandom));

      // Randomized frames with random idle spacing (0 = back-to-back).
      for (int i = 0; i < 6; i++) begin
         r = $urandom_range(0, 3);
         repeat (r) begin
            @(posedge clk); #1;
         end
         r = $urandom_range(0, 2);
         c = (r == 0) ? 4'h1 : (r == 1) ? 4'h2 : 4'($urandom);
         run_frame(c, 16'($urandom), 16'($urandom));
      end

      // Reset during data bit 5 of a read.
      @(posedge clk); #1;
      resp = {8'($urandom), 16'($urandom)};
      rise_cnt = 0;
      start = 1'b1; cmd = 4'h1; wr_data = 16'($urandom);
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 300 && rise_cnt < 14; k++) begin
         @(posedge clk); #1;
      end
      chk1("reached_data_bit5", rise_cnt >= 14, 1'b1);
      dc0 = done_cnt;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk1("mid_rst_csn", cs_n, 1'b1);
      chk1("mid_rst_sclk", sclk, 1'b0);
      chk1("mid_rst_busy", busy, 1'b0);
      chk1("mid_rst_done", done, 1'b0);
      chkn("mid_rst_rd_data", int'(rd_data), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_rd = '0;
      repeat (10) begin
         @(posedge clk); #1;
      end
      chkn("no_done_after_rst", done_cnt, dc0);
      chk1("post_rst_csn", cs_n, 1'b1);
      run_frame(4'h1, 16'($urandom), 16'($urandom));
      run_frame(4'h2, 16'($urandom), 16'($urandom));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
